// File: rtl/button_event_queue_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button event front end.
//   btn_evt_t      : one queued button event, bit i set = button i pressed
//   BTN_FIFO_ADDR  : MMIO address the CPU loads from to pop one event
//   ptr_width()    : FIFO pointer width, one extra wrap bit above the address
// ---------------------------------------------------------------------------
package button_pkg;

  localparam int BTN_WIDTH = 3;

  localparam logic [31:0] BTN_FIFO_ADDR = 32'h8000_0024;

  typedef logic [BTN_WIDTH-1:0] btn_evt_t;

  // The extra MSB lets full and empty be told apart when the address bits match
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/button_event_queue_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Two-flop synchronizer, shared sample tick and one saturating debounce
// counter per button.  A button reads as pressed once it has been seen high
// on PULSE_CNT_MAX consecutive sample ticks.
// Ports:
//   clk            core clock
//   rst            asynchronous reset, active low
//   buttons_raw    raw asynchronous button pins   [WIDTH]
//   clean_buttons  debounced button levels        [WIDTH]
// ---------------------------------------------------------------------------
module button_debouncer
  import button_pkg::*;
#(
  parameter int SAMPLE_CNT_MAX = 50_000,
  parameter int PULSE_CNT_MAX  = 25,
  parameter int WIDTH          = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] buttons_raw,
  output logic [WIDTH-1:0] clean_buttons
);

  localparam int SAMPLE_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int PULSE_W  = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [PULSE_W-1:0]  PULSE_TOP   = PULSE_W'(PULSE_CNT_MAX);

  logic [WIDTH-1:0]    sync0;
  logic [WIDTH-1:0]    sync1;
  logic [SAMPLE_W-1:0] sample_cnt;
  logic                tick;
  logic [PULSE_W-1:0]  cnt [WIDTH];

  // Two-stage synchronizer; reset clears it so debounce restarts from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= buttons_raw;
      sync1 <= sync0;
    end
  end

  assign tick = (sample_cnt == SAMPLE_LAST);

  // Free-running sample divider, wraps after the tick cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + SAMPLE_W'(1);
    end
  end

  // Per-button counters: any low sample clears, high samples count up and hold at the top
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!sync1[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != PULSE_TOP) begin
          cnt[i] <= cnt[i] + PULSE_W'(1);
        end
      end
    end
  end

  // A button is clean-high only while its counter sits at saturation
  always_comb begin
    clean_buttons = '0;
    for (int i = 0; i < WIDTH; i++) clean_buttons[i] = (cnt[i] == PULSE_TOP);
  end

endmodule

// File: rtl/button_event_queue.sv
// ---------------------------------------------------------------------------
// button_event_queue
// Button front end for the CPU's MMIO space: debounces the raw buttons,
// detects debounced rising edges and queues each non-zero edge vector as one
// event in a first-word-fall-through FIFO.  The CPU pops one event per load
// from BTN_FIFO_ADDR.
// Ports:
//   clk            core clock
//   rst            asynchronous reset, active low
//   buttons_raw    raw button pins                         [WIDTH]
//   pop            CPU load of the FIFO address, consumes the head
//   clean_buttons  debounced levels                        [WIDTH]
//   rise_pulse     one-cycle pulse per debounced rising edge [WIDTH]
//   evt_dout       head event, 0 when empty                [WIDTH]
//   evt_valid      FIFO not empty
//   evt_full       FIFO holds FIFO_DEPTH entries
//   ovf_cnt        dropped-event count                     [16]
// Build option:
//   BTN_EVT_OVF_CNT_EN  when defined, ovf_cnt counts dropped pushes
//                       (saturating, cleared only by reset); otherwise it
//                       is tied to 0.
// ---------------------------------------------------------------------------
module button_event_queue
  import button_pkg::*;
#(
  parameter int CLOCK_FREQ     = 50_000_000,
  parameter int SAMPLE_RATE_HZ = 1_000,
  parameter int PULSE_CNT_MAX  = 25,
  parameter int WIDTH          = 3,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] buttons_raw,
  input  logic             pop,
  output logic [WIDTH-1:0] clean_buttons,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] evt_dout,
  output logic             evt_valid,
  output logic             evt_full,
  output logic [15:0]      ovf_cnt
);

  localparam int SAMPLE_CNT_MAX = CLOCK_FREQ / SAMPLE_RATE_HZ;
  localparam int PTR_W          = ptr_width(FIFO_DEPTH);
  localparam int ADDR_W         = PTR_W - 1;

  logic [WIDTH-1:0] clean_d1;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             do_push;
  logic             do_pop;

  button_debouncer #(
    .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX),
    .PULSE_CNT_MAX  (PULSE_CNT_MAX),
    .WIDTH          (WIDTH)
  ) u_debouncer (
    .clk           (clk),
    .rst           (rst),
    .buttons_raw   (buttons_raw),
    .clean_buttons (clean_buttons)
  );

  // Delayed copy of the clean levels for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clean_d1 <= '0;
    end else begin
      clean_d1 <= clean_buttons;
    end
  end

  assign rise_pulse = clean_buttons & ~clean_d1;
  assign push       = |rise_pulse;

  assign evt_valid = (wr_ptr != rd_ptr);
  assign evt_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // alongside a pop still lands (it overwrites the slot being retired).
  assign do_pop  = pop & evt_valid;
  assign do_push = push & (~evt_full | do_pop);

  assign evt_dout = evt_valid ? mem[rd_ptr[ADDR_W-1:0]] : '0;

  // FIFO storage and pointers; pointers wrap through the extra MSB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[ADDR_W-1:0]] <= rise_pulse;
        wr_ptr                  <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

`ifdef BTN_EVT_OVF_CNT_EN
  logic drop;

  assign drop = push & evt_full & ~do_pop;

  // Saturating count of events lost to a full FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`else
  assign ovf_cnt = '0;
`endif

endmodule
